// File: rtl/pe_conv1_pkg.sv
// rtl/pe_conv1_pkg.sv - shared types and default latencies for the conv1 MAC sequencer
// Purpose: state enum and default pipeline latencies shared by the conv1 controller,
//          its bus interface and its stage timer.
package pe_conv1_pkg;

    localparam int CONV1_TAPS         = 9;
    localparam int CONV1_GROUPS       = 3;
    localparam int CONV1_DSP_LAT      = 3;
    localparam int CONV1_ADDER_LAT    = 2;
    localparam int CONV1_DEQUANT_LAT  = 4;
    localparam int CONV1_ACT_LAT      = 1;
    localparam int CONV1_QUANT_LAT    = 36;

    // DRAIN..WAITQ must stay contiguous and in pipeline order: the FSM steps
    // through them by incrementing the encoding.
    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_TAP,
        S_DRAIN,
        S_ADD,
        S_MUL,
        S_SUB,
        S_DEQ,
        S_BIAS,
        S_ACT,
        S_QUANT,
        S_WAITQ,
        S_OUT
    } conv1_ctrl_state_e;

endpackage

// File: rtl/pe_conv_mac_ctrl_conv1_if.sv
// rtl/pe_conv_mac_ctrl_conv1_if.sv - control/handshake bundle of the conv1 MAC sequencer
// Purpose: groups every non-clock/reset signal of the sequencer.
// master modport: the sequencer (drives enables, addresses, in_ready, out_valid).
// slave modport : the datapath/line-buffer side (drives start, in_valid, out_ready).
interface pe_conv_mac_ctrl_conv1_if #(
    parameter int pGROUPS      = pe_conv1_pkg::CONV1_GROUPS,
    parameter int pKERNEL_TAPS = pe_conv1_pkg::CONV1_TAPS
) ();
    localparam int GW = $clog2(pGROUPS);
    localparam int KW = $clog2(pGROUPS * pKERNEL_TAPS);

    logic          start;
    logic          busy;
    logic          done;
    logic          in_valid;
    logic          in_ready;
    logic [GW-1:0] in_group;
    logic          clr;
    logic          clr_weight;
    logic          en;
    logic          adder_en;
    logic          adder_en_weight;
    logic          mul_en;
    logic          sub_en;
    logic          dequant_en;
    logic          bias_en;
    logic          act_en;
    logic          quant_en;
    logic [KW-1:0] kernel_addr;
    logic [GW-1:0] bias_addr;
    logic          out_valid;
    logic          out_ready;
    logic [GW-1:0] out_group;
    logic [31:0]   perf_busy_cycles;
    logic [31:0]   perf_stall_cycles;

    modport master (
        input  start, in_valid, out_ready,
        output busy, done, in_ready, in_group, clr, clr_weight, en,
               adder_en, adder_en_weight, mul_en, sub_en, dequant_en, bias_en,
               act_en, quant_en, kernel_addr, bias_addr, out_valid, out_group,
               perf_busy_cycles, perf_stall_cycles
    );

    modport slave (
        output start, in_valid, out_ready,
        input  busy, done, in_ready, in_group, clr, clr_weight, en,
               adder_en, adder_en_weight, mul_en, sub_en, dequant_en, bias_en,
               act_en, quant_en, kernel_addr, bias_addr, out_valid, out_group,
               perf_busy_cycles, perf_stall_cycles
    );

endinterface

// File: rtl/conv1_stage_timer.sv
// rtl/conv1_stage_timer.sv - loadable down-counter timing the fixed-latency pipeline states
// Ports: clk, rst (sync, active-high), load/load_val (preload, value = state length - 1),
//        zero (count has reached 0, i.e. last cycle of the current state).
module conv1_stage_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/pe_conv_mac_ctrl_conv1.sv
// rtl/pe_conv_mac_ctrl_conv1.sv - conv1 MAC datapath sequencer (one pixel, all channel groups)
// Ports: clk, rst (sync, active-high), bus (pe_conv_mac_ctrl_conv1_if.master): start/busy/done,
//        tap handshake in_valid/in_ready, stage enables, kernel/bias addresses,
//        result handshake out_valid/out_ready/out_group, perf counters.
// Optional feature: CONV1_CTRL_PERF_CNT_EN builds the busy/stall counters; otherwise they read 0.
module pe_conv_mac_ctrl_conv1
    import pe_conv1_pkg::*;
#(
    parameter int pKERNEL_TAPS = CONV1_TAPS,
    parameter int pGROUPS      = CONV1_GROUPS,
    parameter int pDSP_LAT     = CONV1_DSP_LAT,
    parameter int pADDER_LAT   = CONV1_ADDER_LAT,
    parameter int pDEQUANT_LAT = CONV1_DEQUANT_LAT,
    parameter int pACT_LAT     = CONV1_ACT_LAT,
    parameter int pQUANT_LAT   = CONV1_QUANT_LAT
) (
    input logic                      clk,
    input logic                      rst,
    pe_conv_mac_ctrl_conv1_if.master bus
);
    localparam int GW  = $clog2(pGROUPS);
    localparam int KW  = $clog2(pGROUPS * pKERNEL_TAPS);
    localparam int TPW = $clog2(pKERNEL_TAPS);
    localparam int TW  = $clog2(pDSP_LAT + pADDER_LAT + pDEQUANT_LAT + pACT_LAT + pQUANT_LAT + 2);

    // Timer preload per state. WAITQ runs one cycle past the divider latency so the
    // divider result is registered before out_valid is raised.
    function automatic logic [TW-1:0] stage_len_m1(input conv1_ctrl_state_e s);
        case (s)
            S_DRAIN: return TW'(pDSP_LAT - 1);
            S_ADD:   return TW'(pADDER_LAT - 1);
            S_DEQ:   return TW'(pDEQUANT_LAT - 1);
            S_ACT:   return TW'(pACT_LAT - 1);
            S_WAITQ: return TW'(pQUANT_LAT);
            default: return '0;
        endcase
    endfunction

    conv1_ctrl_state_e state_q, state_d;
    logic [TPW-1:0] tap_q, tap_d;
    logic [GW-1:0]  group_q, group_d;
    logic [KW-1:0]  kaddr_q, kaddr_d;
    logic done_q, done_d, busy_q, busy_d, in_ready_q, in_ready_d, clr_q, clr_d;
    logic adder_q, adder_d, mul_q, mul_d, sub_q, sub_d, deq_q, deq_d;
    logic bias_q, bias_d, act_q, act_d, quant_q, quant_d, out_valid_q, out_valid_d;
    logic en, tmr_load, tmr_zero;
    logic [TW-1:0] tmr_val;

    assign en = bus.in_valid & in_ready_q;

    conv1_stage_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        group_d = group_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CLR;
                    group_d = '0;
                    tap_d   = '0;
                end
            end
            S_CLR: state_d = S_TAP;
            S_TAP: begin
                if (en) begin
                    if (tap_q == TPW'(pKERNEL_TAPS - 1)) begin
                        tap_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        tap_d = tap_q + 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    if (group_q == GW'(pGROUPS - 1)) begin
                        state_d = S_IDLE;
                        group_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        group_d = group_q + 1'b1;
                        state_d = S_CLR;
                    end
                end
            end
            // DRAIN..WAITQ: fixed-length stages, advance when the timer expires.
            default: begin
                if (tmr_zero) begin
                    state_d = conv1_ctrl_state_e'(state_q + 4'd1);
                end
            end
        endcase

        tmr_load = (state_d != state_q);
        tmr_val  = stage_len_m1(state_d);

        // Outputs are decoded from the next state so they come straight out of flops.
        busy_d      = (state_d != S_IDLE);
        in_ready_d  = (state_d == S_TAP);
        clr_d       = (state_d == S_CLR);
        adder_d     = (state_d == S_ADD);
        mul_d       = (state_d == S_MUL);
        sub_d       = (state_d == S_SUB);
        deq_d       = (state_d == S_DEQ);
        bias_d      = (state_d == S_BIAS);
        act_d       = (state_d == S_ACT);
        quant_d     = (state_d == S_QUANT);
        out_valid_d = (state_d == S_OUT);
        kaddr_d     = KW'(group_d) * KW'(pKERNEL_TAPS) + KW'(tap_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tap_q       <= '0;
            group_q     <= '0;
            kaddr_q     <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            clr_q       <= 1'b0;
            adder_q     <= 1'b0;
            mul_q       <= 1'b0;
            sub_q       <= 1'b0;
            deq_q       <= 1'b0;
            bias_q      <= 1'b0;
            act_q       <= 1'b0;
            quant_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            group_q     <= group_d;
            kaddr_q     <= kaddr_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            clr_q       <= clr_d;
            adder_q     <= adder_d;
            mul_q       <= mul_d;
            sub_q       <= sub_d;
            deq_q       <= deq_d;
            bias_q      <= bias_d;
            act_q       <= act_d;
            quant_q     <= quant_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.in_ready        = in_ready_q;
    assign bus.in_group        = group_q;
    assign bus.clr             = clr_q;
    assign bus.clr_weight      = clr_q;
    assign bus.en              = en;
    assign bus.adder_en        = adder_q;
    assign bus.adder_en_weight = adder_q;
    assign bus.mul_en          = mul_q;
    assign bus.sub_en          = sub_q;
    assign bus.dequant_en      = deq_q;
    assign bus.bias_en         = bias_q;
    assign bus.act_en          = act_q;
    assign bus.quant_en        = quant_q;
    assign bus.kernel_addr     = kaddr_q;
    assign bus.bias_addr       = group_q;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_group       = group_q;

`ifdef CONV1_CTRL_PERF_CNT_EN
    logic [31:0] perf_busy_q, perf_busy_d, perf_stall_q, perf_stall_d;
    logic        stall;

    always_comb begin
        stall        = ((state_q == S_TAP) && !bus.in_valid) ||
                       ((state_q == S_OUT) && !bus.out_ready);
        perf_busy_d  = perf_busy_q;
        perf_stall_d = perf_stall_q;
        if (busy_q && (perf_busy_q != '1)) begin
            perf_busy_d = perf_busy_q + 1'b1;
        end
        if (stall && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_busy_q  <= perf_busy_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign bus.perf_busy_cycles  = perf_busy_q;
    assign bus.perf_stall_cycles = perf_stall_q;
`else
    assign bus.perf_busy_cycles  = '0;
    assign bus.perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pe_conv_mac_ctrl_conv1.sv
// tb/tb_pe_conv_mac_ctrl_conv1.sv - self-checking bench for the conv1 MAC sequencer
module tb_pe_conv_mac_ctrl_conv1;
    localparam int G  = 3;
    localparam int KT = 9;
    localparam int D  = 3;
    localparam int A  = 2;
    localparam int Q  = 4;
    localparam int AC = 1;
    localparam int QL = 36;
    localparam int L  = D + A + Q + AC + QL + 5;

    // Pipeline-phase offsets, counted from the first cycle after the 9th tap.
    localparam int P_ADD  = D + 1;
    localparam int P_MUL  = D + A + 1;
    localparam int P_SUB  = P_MUL + 1;
    localparam int P_DEQ  = P_SUB + 1;
    localparam int P_BIAS = P_DEQ + Q;
    localparam int P_ACT  = P_BIAS + 1;
    localparam int P_QNT  = P_ACT + AC;

    localparam int PH_IDLE = 0, PH_CLR = 1, PH_TAP = 2, PH_PIPE = 3, PH_OUT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pe_conv_mac_ctrl_conv1_if #(.pGROUPS(G), .pKERNEL_TAPS(KT)) bus ();

    pe_conv_mac_ctrl_conv1 #(
        .pKERNEL_TAPS (KT),
        .pGROUPS      (G),
        .pDSP_LAT     (D),
        .pADDER_LAT   (A),
        .pDEQUANT_LAT (Q),
        .pACT_LAT     (AC),
        .pQUANT_LAT   (QL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: a pixel is CLR, 9 accepted taps, an L-cycle pipeline, OUT.
    int     m_phase, m_taps, m_group, m_p;
    bit     m_done;
    longint m_busy, m_stall;
    bit     i_start, i_iv, i_ordy, i_rst;
    int     ivl, orl, done_cyc;
    int     en_cnt[G];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit win(input int lo, input int len);
        return (m_phase == PH_PIPE) && (m_p >= lo) && (m_p < lo + len);
    endfunction

    task automatic model_adv();
        if (i_rst) begin
            m_phase = PH_IDLE; m_taps = 0; m_group = 0; m_p = 0;
            m_done = 0; m_busy = 0; m_stall = 0;
        end else begin
            if (m_phase != PH_IDLE) m_busy++;
            if ((m_phase == PH_TAP && !i_iv) || (m_phase == PH_OUT && !i_ordy)) m_stall++;
            m_done = 0;
            case (m_phase)
                PH_IDLE: if (i_start) begin m_phase = PH_CLR; m_group = 0; end
                PH_CLR:  begin m_phase = PH_TAP; m_taps = 0; end
                PH_TAP:  if (i_iv) begin
                             m_taps++;
                             if (m_taps == KT) begin m_taps = 0; m_phase = PH_PIPE; m_p = 1; end
                         end
                PH_PIPE: if (m_p == L) m_phase = PH_OUT; else m_p++;
                PH_OUT:  if (i_ordy) begin
                             if (m_group == G - 1) begin
                                 m_phase = PH_IDLE; m_group = 0; m_done = 1;
                             end else begin
                                 m_group++; m_phase = PH_CLR;
                             end
                         end
                default: m_phase = PH_IDLE;
            endcase
        end
    endtask

    task automatic compare();
        logic [14:0] ectl, actl;
        logic [10:0] eaddr, aaddr;
        bit tap;
        tap  = (m_phase == PH_TAP);
        ectl = {m_phase != PH_IDLE, m_done, tap, tap && i_iv,
                m_phase == PH_CLR, m_phase == PH_CLR,
                win(P_ADD, A), win(P_ADD, A), win(P_MUL, 1), win(P_SUB, 1),
                win(P_DEQ, Q), win(P_BIAS, 1), win(P_ACT, AC), win(P_QNT, 1),
                m_phase == PH_OUT};
        actl = {bus.busy, bus.done, bus.in_ready, bus.en, bus.clr, bus.clr_weight,
                bus.adder_en, bus.adder_en_weight, bus.mul_en, bus.sub_en,
                bus.dequant_en, bus.bias_en, bus.act_en, bus.quant_en, bus.out_valid};
        check($sformatf("ctl@%0d", cyc), actl, ectl);
        eaddr = {2'(m_group), 5'(m_group * KT + m_taps), 2'(m_group), 2'(m_group)};
        aaddr = {bus.in_group, bus.kernel_addr, bus.bias_addr, bus.out_group};
        check($sformatf("addr@%0d", cyc), aaddr, eaddr);
`ifdef CONV1_CTRL_PERF_CNT_EN
        check($sformatf("perf_busy@%0d", cyc), bus.perf_busy_cycles, m_busy);
        check($sformatf("perf_stall@%0d", cyc), bus.perf_stall_cycles, m_stall);
`else
        check($sformatf("perf_off@%0d", cyc), {bus.perf_busy_cycles, bus.perf_stall_cycles}, 64'd0);
`endif
        if (bus.en && m_group < G) en_cnt[m_group]++;
        if (bus.done) done_cyc = cyc;
    endtask

    // One clock: model follows the edge, then new inputs are chosen from the
    // model's view of the current cycle, then outputs are checked mid-cycle.
    task automatic cycle(input int mode, input bit first);
        bit s, iv, ordy, r;
        @(posedge clk);
        cyc++;
        model_adv();
        #1;
        s = first; iv = 1'b1; ordy = 1'b1; r = 1'b0;
        case (mode)
            1, 3: begin
                iv   = ($urandom_range(0, 9) < 7);
                ordy = ($urandom_range(0, 9) < 6);
                if (mode == 3 && !first) s = ($urandom_range(0, 5) == 0);
            end
            2: begin
                iv = ($urandom_range(0, 3) != 0);
                r  = (m_phase == PH_PIPE && m_group == 1 && m_p == 20);
            end
            4: begin
                if (m_phase == PH_TAP && m_group == 0 && m_taps == 4 && ivl < 5) begin
                    iv = 1'b0; ivl++;
                end
                if (m_phase == PH_OUT && m_group == 1 && orl < 10) begin
                    ordy = 1'b0; orl++;
                end
            end
            9: begin s = 0; iv = 0; ordy = 0; r = 1'b1; end
            default: ;
        endcase
        rst = r; bus.start = s; bus.in_valid = iv; bus.out_ready = ordy;
        i_rst = r; i_start = s; i_iv = iv; i_ordy = ordy;
        @(negedge clk);
        compare();
    endtask

    task automatic run_pixel(input int mode);
        int n, start_cyc;
        for (int g = 0; g < G; g++) en_cnt[g] = 0;
        ivl = 0; orl = 0; done_cyc = -1;
        cycle(mode, 1'b1);
        start_cyc = cyc;
        n = 0;
        while (n < 3000) begin
            cycle(mode, 1'b0);
            n++;
            if (m_phase == PH_IDLE) break;
        end
        check("pixel_within_budget", n < 3000, 1);
        if (mode == 2) begin
            check("no_done_on_abort", done_cyc == -1, 1);
        end else begin
            for (int g = 0; g < G; g++) check($sformatf("en_count_g%0d", g), en_cnt[g], KT);
        end
        if (mode == 0) check("done_latency", done_cyc - start_cyc, 187);
        if (mode == 4) begin
            check("done_latency_stalled", done_cyc - start_cyc, 187 + 15);
`ifdef CONV1_CTRL_PERF_CNT_EN
            check("stall_total", bus.perf_stall_cycles, 15);
`endif
        end
    endtask

    initial begin
        rst = 1'b1; bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        i_rst = 1'b1; i_start = 0; i_iv = 0; i_ordy = 0;
        m_phase = PH_IDLE; m_taps = 0; m_group = 0; m_p = 0; m_done = 0;
        m_busy = 0; m_stall = 0;
        cycle(9, 1'b0);
        cycle(9, 1'b0);
        run_pixel(0);
        cycle(9, 1'b0);
        run_pixel(4);
        run_pixel(2);
        run_pixel(0);
        for (int k = 0; k < 3; k++) run_pixel(3);
        for (int k = 0; k < 4; k++) run_pixel(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
